// File: rtl/bus_src_arbiter_if.sv
// Request/grant bundle between the bus sources and the source arbiter.
// Sources drive out_req/bus_hold; the arbiter returns select, grant and status.
interface bus_src_arbiter_if #(
    parameter int NSRC  = 24,
    parameter int SEL_W = 5
);
    logic [NSRC-1:0]  out_req;
    logic             bus_hold;
    logic [SEL_W-1:0] bus_signal;
    logic             bus_valid;
    logic [NSRC-1:0]  grant;
    logic [4:0]       pend_cnt;
    logic             err_rsvd;

    modport master (
        output out_req,
        output bus_hold,
        input  bus_signal,
        input  bus_valid,
        input  grant,
        input  pend_cnt,
        input  err_rsvd
    );

    modport slave (
        input  out_req,
        input  bus_hold,
        output bus_signal,
        output bus_valid,
        output grant,
        output pend_cnt,
        output err_rsvd
    );
endinterface

// File: rtl/bus_src_arbiter.sv
// Pending-set bus source arbiter driving the 5-bit bus mux select.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin; default is lowest-index-wins.
module bus_src_arbiter #(
    parameter int NSRC      = 24,
    parameter int SEL_W     = 5,
    parameter int RSVD_CODE = 22
) (
    input  logic             clock,
    input  logic             clear,
    bus_src_arbiter_if.slave bus
);

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [NSRC-1:0] ONE       = NSRC'(1);
    localparam logic [NSRC-1:0] RSVD_MASK = ONE << RSVD_CODE;

    logic [NSRC-1:0]  pend;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] sig_q;
    logic             valid_q;
    logic [NSRC-1:0]  grant_q;
    logic [4:0]       cnt_q;
    logic             err_q;

    logic [NSRC-1:0]  req_f;
    logic [NSRC-1:0]  cand;
    logic [NSRC-1:0]  pend_nxt;
    logic [SEL_W-1:0] win;
    logic             found;
    logic [SEL_W-1:0] sig_nxt;
    logic             valid_nxt;
    logic [NSRC-1:0]  grant_nxt;
    logic [SEL_W-1:0] last_nxt;
    logic [4:0]       cnt_nxt;
    int               start;
    int               idx;

    always_comb begin
        req_f = bus.out_req & ~RSVD_MASK;
        cand  = pend | req_f;
    end

    // Fixed priority always searches from code 0.
    always_comb begin
        start = 0;
        if (RR) begin
            start = int'(last) + 1;
            if (start >= NSRC) begin
                start = 0;
            end
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NSRC; i++) begin
            idx = start + i;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = SEL_W'(idx);
            end
        end
    end

    // Idle keeps the select: the bus mux holds on its default.
    always_comb begin
        pend_nxt  = cand;
        sig_nxt   = sig_q;
        valid_nxt = valid_q;
        grant_nxt = grant_q;
        last_nxt  = last;
        if (!bus.bus_hold) begin
            if (found) begin
                sig_nxt   = win;
                valid_nxt = 1'b1;
                grant_nxt = ONE << win;
                last_nxt  = win;
                pend_nxt  = cand & ~(ONE << win);
            end else begin
                valid_nxt = 1'b0;
                grant_nxt = '0;
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NSRC; i++) begin
            cnt_nxt = cnt_nxt + {4'd0, pend_nxt[i]};
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pend    <= '0;
            last    <= SEL_W'(NSRC - 1);
            sig_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            pend    <= pend_nxt;
            last    <= last_nxt;
            sig_q   <= sig_nxt;
            valid_q <= valid_nxt;
            grant_q <= grant_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_q | bus.out_req[RSVD_CODE];
        end
    end

    assign bus.bus_signal = sig_q;
    assign bus.bus_valid  = valid_q;
    assign bus.grant      = grant_q;
    assign bus.pend_cnt   = cnt_q;
    assign bus.err_rsvd   = err_q;

endmodule

// File: tb/tb_bus_src_arbiter.sv
// Scoreboard bench for bus_src_arbiter: directed test-plan cases plus random traffic
// checked against a set-based reference model of the arbitration rules.
module tb_bus_src_arbiter;

    localparam int NSRC = 24;
    localparam int RSVD = 22;

    typedef struct {
        int sig;
        int valid;
        int grant;
        int cnt;
        int err;
    } exp_t;

    logic clk;
    logic clear;
    int   checks;
    int   errors;
    exp_t sb[$];

    bit pend_m[NSRC];
    int last_m;
    int sig_m;
    int val_m;
    int err_m;

    bus_src_arbiter_if #(.NSRC(NSRC), .SEL_W(5)) bif ();

    bus_src_arbiter #(
        .NSRC(NSRC),
        .SEL_W(5),
        .RSVD_CODE(RSVD)
    ) dut (
        .clock(clk),
        .clear(clear),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) pend_m[i] = 0;
        last_m = NSRC - 1;
        sig_m  = 0;
        val_m  = 0;
        err_m  = 0;
    endtask

    // Reference: a set of waiting sources; pick one, remove it, count what remains.
    task automatic model_step(input logic [NSRC-1:0] req, input logic hold);
        bit   cand[NSRC];
        int   w;
        int   n;
        exp_t e;
        if (req[RSVD]) err_m = 1;
        for (int i = 0; i < NSRC; i++) cand[i] = pend_m[i] || (req[i] && i != RSVD);
        w = -1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NSRC; k++) begin
            if (w < 0 && cand[(last_m + k) % NSRC]) w = (last_m + k) % NSRC;
        end
`else
        for (int i = NSRC - 1; i >= 0; i--) if (cand[i]) w = i;
`endif
        if (!hold) begin
            if (w >= 0) begin
                sig_m   = w;
                val_m   = 1;
                last_m  = w;
                cand[w] = 0;
            end else begin
                val_m = 0;
            end
        end
        n = 0;
        for (int i = 0; i < NSRC; i++) begin
            pend_m[i] = cand[i];
            n += cand[i] ? 1 : 0;
        end
        e.sig   = sig_m;
        e.valid = val_m;
        e.grant = val_m ? (1 << sig_m) : 0;
        e.cnt   = n;
        e.err   = err_m;
        sb.push_back(e);
    endtask

    task automatic step(input logic [NSRC-1:0] req, input logic hold);
        @(negedge clk);
        bif.out_req  = req;
        bif.bus_hold = hold;
        model_step(req, hold);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_clear();
        @(negedge clk);
        bif.out_req  = '0;
        bif.bus_hold = 1'b0;
        #2 clear = 1'b0;
        #1;
        chk("rst_sig", int'(bif.bus_signal), 0);
        chk("rst_valid", int'(bif.bus_valid), 0);
        chk("rst_grant", int'(bif.grant), 0);
        chk("rst_cnt", int'(bif.pend_cnt), 0);
        chk("rst_err", int'(bif.err_rsvd), 0);
        model_reset();
        @(negedge clk);
        clear = 1'b1;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_sig", int'(bif.bus_signal), e.sig);
            chk("sb_valid", int'(bif.bus_valid), e.valid);
            chk("sb_grant", int'(bif.grant), e.grant);
            chk("sb_cnt", int'(bif.pend_cnt), e.cnt);
            chk("sb_err", int'(bif.err_rsvd), e.err);
        end
    end

    initial begin
        logic [NSRC-1:0] r;
        logic            h;
        checks = 0;
        errors = 0;
        clear = 1'b0;
        bif.out_req  = '0;
        bif.bus_hold = 1'b0;
        model_reset();
        #12 clear = 1'b1;

        // Single PC request, then idle keeps the select
        do_clear();
        step(24'h100000, 1'b0);
        after_edge();
        chk("pc_sig", int'(bif.bus_signal), 20);
        chk("pc_grant", int'(bif.grant), 32'h100000);
        chk("pc_valid", int'(bif.bus_valid), 1);
        chk("pc_cnt", int'(bif.pend_cnt), 0);
        step(24'h0, 1'b0);
        after_edge();
        chk("idle_valid", int'(bif.bus_valid), 0);
        chk("idle_sig", int'(bif.bus_signal), 20);

        // Three simultaneous requests
        do_clear();
        step((24'd1 << 3) | (24'd1 << 16) | (24'd1 << 21), 1'b0);
        after_edge();
        chk("tri_sig0", int'(bif.bus_signal), 3);
        chk("tri_cnt0", int'(bif.pend_cnt), 2);
`ifdef BUS_ARB_ROUND_ROBIN_EN
        step(24'h0, 1'b0);
        after_edge();
        chk("rr_sig1", int'(bif.bus_signal), 16);
        chk("rr_cnt1", int'(bif.pend_cnt), 1);
        step(24'h0, 1'b0);
        after_edge();
        chk("rr_sig2", int'(bif.bus_signal), 21);
        chk("rr_cnt2", int'(bif.pend_cnt), 0);
`else
        for (int i = 0; i < 3; i++) begin
            step(24'd1 << 3, 1'b0);
            after_edge();
            chk("fp_sig", int'(bif.bus_signal), 3);
            chk("fp_cnt", int'(bif.pend_cnt), 2);
        end
`endif

        // Hold freezes R5 while 7 and 9 accumulate
        do_clear();
        step(24'd1 << 5, 1'b0);
        after_edge();
        chk("hold_sig0", int'(bif.bus_signal), 5);
        for (int i = 0; i < 2; i++) begin
            step((24'd1 << 7) | (24'd1 << 9), 1'b1);
            after_edge();
            chk("hold_sig", int'(bif.bus_signal), 5);
            chk("hold_valid", int'(bif.bus_valid), 1);
            chk("hold_cnt", int'(bif.pend_cnt), 2);
        end
        step(24'h0, 1'b0);
        after_edge();
        chk("rel_sig7", int'(bif.bus_signal), 7);
        step(24'h0, 1'b0);
        after_edge();
        chk("rel_sig9", int'(bif.bus_signal), 9);

        // Reserved code is rejected and flagged until clear
        do_clear();
        step(24'd1 << RSVD, 1'b0);
        after_edge();
        chk("rsvd_err", int'(bif.err_rsvd), 1);
        chk("rsvd_valid", int'(bif.bus_valid), 0);
        for (int i = 0; i < 3; i++) step(24'h0, 1'b0);
        after_edge();
        chk("rsvd_sticky", int'(bif.err_rsvd), 1);

        // Clear discards a pending set of four
        do_clear();
        step((24'd1 << 1) | (24'd1 << 2) | (24'd1 << 4) | (24'd1 << 6), 1'b1);
        after_edge();
        chk("pre_clr_cnt", int'(bif.pend_cnt), 4);
        do_clear();
        step(24'd1 << 23, 1'b0);
        after_edge();
        chk("post_clr_sig", int'(bif.bus_signal), 23);
        chk("post_clr_valid", int'(bif.bus_valid), 1);
        step(24'h0, 1'b0);
        after_edge();
        chk("post_clr_idle", int'(bif.bus_valid), 0);
        chk("post_clr_cnt", int'(bif.pend_cnt), 0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_clear();
            end else begin
                r = NSRC'($urandom & $urandom & $urandom);
                if ($urandom_range(0, 19) != 0) r[RSVD] = 1'b0;
                h = ($urandom_range(0, 4) == 0);
                step(r, h);
            end
        end

        after_edge();
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
